// File: rtl/bin2bcd_seq_if.sv
// Purpose: start/busy/done handshake and data bus of the sequential binary-to-BCD converter.
// Latency: none (wiring only).
// Backpressure: none; the master must not expect start to be honoured while busy is high.
//
// Ports (signals):
//   start   master->slave  request conversion of bin_in
//   bin_in  master->slave  unsigned operand, BIN_W bits
//   busy    slave->master  conversion in progress
//   done    slave->master  one-cycle pulse when bcd_out is updated
//   bcd_out slave->master  packed BCD result, digit 0 (units) in [3:0]
interface bin2bcd_seq_if #(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3
);
   logic                  start;
   logic [BIN_W-1:0]      bin_in;
   logic                  busy;
   logic                  done;
   logic [4*DIGITS-1:0]   bcd_out;

   modport master (output start, output bin_in, input busy, input done, input bcd_out);
   modport slave  (input start, input bin_in, output busy, output done, output bcd_out);
endinterface

// File: rtl/bin2bcd_seq.sv
// Purpose: sequential double-dabble binary-to-BCD converter, one bit per clock.
// Latency: done/bcd_out BIN_W cycles after the accepting edge; one conversion per BIN_W+1 cycles.
// Backpressure: start is ignored while busy; start in the done cycle is accepted back-to-back.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    slave side of bin2bcd_seq_if (start, bin_in in; busy, done, bcd_out out)
module bin2bcd_seq #(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   bin2bcd_seq_if.slave    bus
);

   localparam int SW = 4*DIGITS + BIN_W;
   localparam int CW = $clog2(BIN_W + 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   function automatic longint pow10(input int n);
      longint r;
      r = 1;
      for (int i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction

   // The BCD field must be able to hold the largest binary operand.
   if (pow10(DIGITS) <= ((longint'(1) << BIN_W) - 1)) begin : g_bad_digits
      $fatal(1, "bin2bcd_seq: DIGITS=%0d too small for BIN_W=%0d", DIGITS, BIN_W);
   end
   if (BIN_W < 4 || BIN_W > 16) begin : g_bad_width
      $fatal(1, "bin2bcd_seq: BIN_W=%0d outside 4..16", BIN_W);
   end

   logic [1:0]            state_q, state_d;
   logic [SW-1:0]         sh_q, sh_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [4*DIGITS-1:0]   bcd_q, bcd_d;

   logic [SW-1:0]         adj;
   logic [SW-1:0]         sh_next;

   // Add-3 on every BCD nibble >= 5, all in parallel, then shift the whole register.
   // The 4-bit add cannot overflow: 5..9 become 8..12.
   always_comb begin
      adj = sh_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (sh_q[BIN_W+4*i +: 4] >= 4'd5) begin
            adj[BIN_W+4*i +: 4] = sh_q[BIN_W+4*i +: 4] + 4'd3;
         end
      end
      sh_next = adj << 1;
   end

   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      cnt_d   = cnt_q;
      bcd_d   = bcd_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (bus.start) begin
               sh_d    = {{(4*DIGITS){1'b0}}, bus.bin_in};
               cnt_d   = CW'(BIN_W);
               state_d = ST_SHIFT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            sh_d  = sh_next;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               bcd_d   = sh_next[SW-1:BIN_W];
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         sh_q    <= '0;
         cnt_q   <= '0;
         bcd_q   <= '0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         cnt_q   <= cnt_d;
         bcd_q   <= bcd_d;
      end
   end

   // Pure state decodes: no path from inputs to outputs.
   assign bus.busy    = (state_q == ST_SHIFT);
   assign bus.done    = (state_q == ST_DONE);
   assign bus.bcd_out = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

   localparam int BIN_W  = 8;
   localparam int DIGITS = 3;

   logic clk;
   logic rst_n;

   bin2bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

   bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [11:0] sb_q[$];
   logic [11:0] prev_bcd = '0;
   logic [11:0] conv [0:255];

   function automatic logic [11:0] ref_bcd(input int v);
      logic [3:0] h, t, u;
      h = 4'(v / 100);
      t = 4'((v % 100) / 10);
      u = 4'(v % 10);
      return {h, t, u};
   endfunction

   // Single-digit BCD adder model: returns {carry, sum digit}.
   function automatic logic [4:0] bcdadd1(input logic [3:0] a, input logic [3:0] b, input logic cin);
      logic [4:0] s;
      s = {1'b0, a} + {1'b0, b} + {4'b0, cin};
      if (s > 5'd9) begin
         s = s + 5'd6;
         return {1'b1, s[3:0]};
      end
      return {1'b0, s[3:0]};
   endfunction

   // Scoreboard monitor: every done pulse pops one expectation; bcd_out must not move otherwise.
   always @(negedge clk) begin
      logic [11:0] exp_v;
      if (!rst_n) begin
         prev_bcd = bus.bcd_out;
      end else begin
         if (bus.done) begin
            checks++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_done: bcd_out=%h, no result expected", bus.bcd_out);
            end else begin
               exp_v = sb_q.pop_front();
               if (bus.bcd_out !== exp_v) begin
                  errors++;
                  $display("FAIL result: bcd_out=%h expected=%h", bus.bcd_out, exp_v);
               end
            end
            for (int d = 0; d < DIGITS; d++) begin
               checks++;
               if (!(bus.bcd_out[4*d +: 4] <= 4'd9)) begin
                  errors++;
                  $display("FAIL nibble_range: digit %0d = %h, required <= 9", d, bus.bcd_out[4*d +: 4]);
               end
            end
         end else begin
            checks++;
            if (bus.bcd_out !== prev_bcd) begin
               errors++;
               $display("FAIL bcd_stable: bcd_out=%h changed without done, held=%h", bus.bcd_out, prev_bcd);
            end
         end
         prev_bcd = bus.bcd_out;
      end
   end

   // One conversion: checks latency and busy length, returns the result for further use.
   task automatic run_conv(input int v, output logic [11:0] res);
      int n;
      int busy_n;
      @(negedge clk);
      bus.start  = 1'b1;
      bus.bin_in = 8'(v);
      sb_q.push_back(ref_bcd(v));
      @(negedge clk);            // just after the accepting edge
      bus.start  = 1'b0;
      bus.bin_in = 8'($urandom_range(0, 255));
      n = 0;
      busy_n = 0;
      while (!bus.done && n < 50) begin
         if (bus.busy === 1'b1) busy_n++;
         @(negedge clk);
         n++;
      end
      checks++;
      if (n !== BIN_W) begin
         errors++;
         $display("FAIL latency v=%0d: done after %0d cycles, required %0d", v, n, BIN_W);
      end
      checks++;
      if (busy_n !== BIN_W) begin
         errors++;
         $display("FAIL busy_len v=%0d: busy for %0d cycles, required %0d", v, busy_n, BIN_W);
      end
      res = bus.bcd_out;
   endtask

   task automatic test_reset();
      rst_n      = 1'b0;
      bus.start  = 1'b0;
      bus.bin_in = '0;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.bcd_out !== 12'h000) begin
         errors++;
         $display("FAIL reset_state: busy=%b done=%b bcd=%h, required 0 0 000", bus.busy, bus.done, bus.bcd_out);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_zero();
      logic [11:0] r;
      run_conv(0, r);
      checks++;
      if (r !== 12'h000) begin
         errors++;
         $display("FAIL zero: bcd=%h required 000", r);
      end
   endtask

   task automatic test_max();
      logic [11:0] r;
      run_conv(255, r);
      checks++;
      if (r !== 12'h255) begin
         errors++;
         $display("FAIL max: bcd=%h required 255", r);
      end
   endtask

   task automatic test_sweep();
      logic [11:0] r;
      for (int v = 0; v < 256; v++) begin
         run_conv(v, r);
         conv[v] = r;
      end
   endtask

   // Chains three bcdadder_1 digits on two converted operands, compared with the decimal sum.
   task automatic check_add(input int a, input int b);
      logic [4:0]  s;
      logic        c;
      logic [11:0] got;
      c = 1'b0;
      for (int d = 0; d < 3; d++) begin
         s = bcdadd1(conv[a][4*d +: 4], conv[b][4*d +: 4], c);
         got[4*d +: 4] = s[3:0];
         c = s[4];
      end
      checks++;
      if (got !== ref_bcd(a + b) || c !== 1'b0) begin
         errors++;
         $display("FAIL bcd_add %0d+%0d: sum=%h carry=%b, required %h carry 0", a, b, got, c, ref_bcd(a + b));
      end
   endtask

   task automatic test_adder();
      logic [4:0] s;
      int exp_u, exp_c;
      s = bcdadd1(conv[47][3:0], conv[38][3:0], 1'b0);
      exp_u = (47 % 10 + 38 % 10) % 10;
      exp_c = ((47 % 10 + 38 % 10) >= 10) ? 1 : 0;
      checks++;
      if (s[3:0] !== 4'(exp_u) || s[4] !== 1'(exp_c)) begin
         errors++;
         $display("FAIL units_add 47+38: digit=%0d carry=%0d, required %0d %0d", s[3:0], s[4], exp_u, exp_c);
      end
      check_add(47, 38);
      for (int v = 0; v < 256; v += 17) check_add(v, 255 - v);
   endtask

   task automatic test_start_ignored();
      int n;
      int dones;
      @(negedge clk);
      bus.start  = 1'b1;
      bus.bin_in = 8'd99;
      sb_q.push_back(ref_bcd(99));
      @(negedge clk);
      bus.start = 1'b0;
      bus.bin_in = 8'd0;
      @(negedge clk);
      @(negedge clk);
      bus.start  = 1'b1;
      bus.bin_in = 8'd200;
      @(negedge clk);
      bus.start = 1'b0;
      dones = 0;
      n = 0;
      while (n < 30) begin
         if (bus.done === 1'b1) begin
            dones++;
            checks++;
            if (bus.bcd_out !== 12'h099) begin
               errors++;
               $display("FAIL ignore_result: bcd=%h required 099", bus.bcd_out);
            end
         end
         @(negedge clk);
         n++;
      end
      checks++;
      if (dones !== 1) begin
         errors++;
         $display("FAIL ignore_dones: %0d done pulses, required 1", dones);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      @(negedge clk);
      bus.start  = 1'b1;
      bus.bin_in = 8'd123;
      sb_q.push_back(ref_bcd(123));
      n = 0;
      while (!bus.done && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (bus.done !== 1'b1 || bus.bcd_out !== 12'h123 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_first: done=%b busy=%b bcd=%h, required 1 0 123", bus.done, bus.busy, bus.bcd_out);
      end
      bus.bin_in = 8'd45;        // start still high: accepted at the end of this DONE cycle
      sb_q.push_back(ref_bcd(45));
      @(negedge clk);
      bus.start = 1'b0;
      n = 1;
      while (!bus.done && n < 50) begin
         checks++;
         if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_busy: busy=%b at cycle %0d, required 1", bus.busy, n);
         end
         @(negedge clk);
         n++;
      end
      checks++;
      if (n !== BIN_W + 1 || bus.bcd_out !== 12'h045) begin
         errors++;
         $display("FAIL b2b_second: done after %0d cycles bcd=%h, required %0d 045", n, bus.bcd_out, BIN_W + 1);
      end
   endtask

   task automatic test_async_reset();
      logic [11:0] r;
      int dones;
      @(negedge clk);
      bus.start  = 1'b1;
      bus.bin_in = 8'd250;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.bcd_out !== 12'h000) begin
         errors++;
         $display("FAIL async_reset: busy=%b done=%b bcd=%h, required 0 0 000", bus.busy, bus.done, bus.bcd_out);
      end
      dones = 0;
      repeat (3) begin
         @(negedge clk);
         if (bus.done === 1'b1) dones++;
      end
      rst_n = 1'b1;
      repeat (BIN_W + 4) begin
         @(negedge clk);
         if (bus.done === 1'b1) dones++;
      end
      checks++;
      if (dones !== 0) begin
         errors++;
         $display("FAIL reset_no_done: %0d done pulses, required 0", dones);
      end
      run_conv(7, r);
      checks++;
      if (r !== 12'h007) begin
         errors++;
         $display("FAIL after_reset: bcd=%h required 007", r);
      end
   endtask

   initial begin
      test_reset();
      test_zero();
      test_max();
      test_sweep();
      test_adder();
      test_start_ignored();
      test_back_to_back();
      test_async_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d results outstanding, required 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one bit per clock.
- Sits directly upstream of the single-digit BCD adder stage.
- Converts an unsigned binary operand into packed BCD digits; each 4-bit lane feeds one BCD adder digit's a/b input.
- Start/busy/done handshake; the result is held until the next conversion completes.

Parameters:
- BIN_W, 8: width of the binary input in bits, 4..16.
- DIGITS, 3: number of BCD output digits. Must satisfy 10^DIGITS > 2^BIN_W-1. Checked at elaboration with a fatal message if violated.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request conversion of bin_in; sampled on the rising edge.
- bin_in  input  BIN_W  unsigned binary operand, captured on the accepting edge only.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bcd_out is updated.
- bcd_out  output  4*DIGITS  packed BCD result; digit 0 (units) in [3:0], digit i in [4i+3:4i].

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, bcd_out=0, shift register and bit counter cleared. Release is synchronous to the next rising edge of clk.
- Internal state: shift register of 4*DIGITS+BIN_W bits (BCD field above the binary field) and a bit counter of clog2(BIN_W+1) bits.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1: load shift register = {zeros, bin_in}, counter=BIN_W, go to SHIFT.
  - start=0: stay in IDLE.
- SHIFT, each cycle:
  - Every BCD nibble >= 5 gets +3, all nibbles in parallel, combinationally from the current register value.
  - The whole register then shifts left by 1 and the counter decrements.
  - When the counter goes 1->0 (last shift), bcd_out is loaded with the BCD field of the post-shift value and the FSM goes to DONE.
- DONE: done=1 for exactly this cycle.
  - start=1: accepted as in IDLE, back-to-back, next state SHIFT.
  - Otherwise: next state IDLE.
- busy=1 exactly when state=SHIFT.
- start while in SHIFT is ignored. The in-flight conversion is unaffected and bin_in is not captured.
- Latency: start sampled at edge E0.
  - Shifts occur at E1..E(BIN_W); busy is high from E0 to E(BIN_W).
  - done is high between E(BIN_W) and E(BIN_W+1); bcd_out is valid from E(BIN_W).
  - Throughput is one conversion per BIN_W+1 cycles.
- bcd_out changes only at the completing edge or on reset, never mid-conversion. Every output nibble is in 0..9.
- Reset mid-conversion: abort immediately. All outputs return to reset values and no done pulse is produced.
- bin_in may change freely after the accepting edge.
- Arithmetic: the per-nibble add-3 is 4-bit with no carry out. A nibble >= 5 plus 3 never exceeds 12, so the value is correct before the shift.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Zero input: reset, then start with bin_in=0 (BIN_W=8, DIGITS=3) -> done pulses 8 cycles after the accepting edge and bcd_out=12'h000. busy is high for exactly 8 cycles.
- Max input: start with bin_in=255 -> bcd_out=12'h255; every nibble checked to be <= 9.
- Exhaustive sweep: all 256 input values, each compared against a reference model using /100, %100/10 and %10. Digits feed a bcdadder_1 model with carry_in=0, and the BCD sum is checked against the decimal sum of two converted values. Example: 47+38 -> units digit 5 with carry 1.
- Start ignored while busy: start with bin_in=99, then pulse start with bin_in=200 at cycle 3 -> result 12'h099. Exactly one done pulse; the second request is ignored.
- Back-to-back: hold start=1 with 123 then 45 asserted in the DONE cycle -> 12'h123, then 12'h045 with done 9 cycles later. busy deasserts only during the DONE cycle.
- Async reset mid-conversion: assert rst_n=0 at shift 4 of a conversion of 250 -> outputs clear immediately without waiting for a clock edge, and no done pulse. A new start of 7 after release -> 12'h007 with normal latency.
